// File: rtl/bus_responder_pkg.sv
// Shared constants and helpers for the bus_responder slice.
package bus_responder_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned COUNT_W = 16;

    // Galois taps x^16+x^14+x^13+x^11, shared with other stimulus generators
    localparam logic [LFSR_W-1:0] LFSR_MASK         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // One right-shifting Galois LFSR step
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Request/response valid-ready bus between initiator (master) and responder (slave).
interface bus_responder_if #(
    parameter int unsigned data_width = 32,
    parameter int unsigned addr_width = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [addr_width-1:0] req_addr;
    logic [data_width-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_write;
    logic [data_width-1:0] resp_data;
    logic [15:0]           accept_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_data, accept_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_write, resp_data, accept_count
    );
endinterface

// File: rtl/bus_responder_resp_fifo.sv
// Synchronous response FIFO; pointers carry an extra wrap bit for full/empty.
module bus_responder_resp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Status flags and head come straight from the registered pointers
    always_comb begin
        full_o  = (wr_q[IDX_W] != rd_q[IDX_W]) && (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
        empty_o = (wr_q == rd_q);
        head_o  = store_q[rd_q[IDX_W-1:0]];
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = wr_q + PTR_W'(do_push);
        rd_d    = rd_q + PTR_W'(do_pop);
    end

    // Pointer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage; cleared so the idle head reads as zero after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                store_q[i] <= '0;
            end
        end else if (do_push) begin
            store_q[wr_q[IDX_W-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Simulation-side memory responder: in-order responses, optional LFSR back-pressure.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int unsigned        data_width   = 32,
    parameter int unsigned        addr_width   = 8,
    parameter int unsigned        fifo_depth   = 4,
    parameter bit                 stall_enable = FALSE,
    parameter logic [LFSR_W-1:0]  lfsr_seed    = LFSR_SEED_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    bus_responder_if.slave    bus
);
    localparam int unsigned MEM_WORDS = 1 << addr_width;
    localparam int unsigned ENTRY_W   = data_width + 1;

    logic [data_width-1:0] mem_q [MEM_WORDS];
    logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
    logic [COUNT_W-1:0]    count_q, count_d;

    logic                  stall_c;
    logic                  ready_c;
    logic                  fire_c;
    logic                  pop_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    push_entry_c;
    logic [ENTRY_W-1:0]    head_entry;

    // Handshake glue; ready never looks at resp_ready, so a full FIFO blocks even on pop
    always_comb begin
        stall_c      = stall_enable && lfsr_q[0];
        ready_c      = !fifo_full && !stall_c;
        fire_c       = bus.req_valid && ready_c;
        pop_c        = !fifo_empty && bus.resp_ready;
        push_entry_c = bus.req_write ? {1'b1, bus.req_wdata}
                                     : {1'b0, mem_q[bus.req_addr]};
        lfsr_d       = lfsr_next(lfsr_q);
        count_d      = count_q + COUNT_W'(fire_c);
    end

    // LFSR free-runs every cycle; accept counter wraps naturally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q  <= lfsr_seed;
            count_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
        end
    end

    // Word memory, zeroed on reset; reads above see the pre-edge contents
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (fire_c && bus.req_write) begin
            mem_q[bus.req_addr] <= bus.req_wdata;
        end
    end

    bus_responder_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (fifo_depth)
    ) u_resp_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fire_c),
        .pop_i   (pop_c),
        .din_i   (push_entry_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_entry)
    );

    assign bus.req_ready    = ready_c;
    assign bus.resp_valid   = !fifo_empty;
    assign bus.resp_write   = head_entry[ENTRY_W-1];
    assign bus.resp_data    = head_entry[data_width-1:0];
    assign bus.accept_count = count_q;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed and random traffic against a queue/array model.
module tb_bus_responder;
    import bus_responder_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst0;
    logic rst1;

    int checks = 0;
    int errors = 0;

    bus_responder_if #(.data_width(32), .addr_width(8)) bi0 ();
    bus_responder_if #(.data_width(32), .addr_width(8)) bi1 ();

    bus_responder #(
        .data_width(32), .addr_width(8), .fifo_depth(DEPTH),
        .stall_enable(FALSE), .lfsr_seed(16'hACE1)
    ) dut0 (.clock(clk), .reset(rst0), .bus(bi0));

    bus_responder #(
        .data_width(32), .addr_width(8), .fifo_depth(DEPTH),
        .stall_enable(TRUE), .lfsr_seed(16'hACE1)
    ) dut1 (.clock(clk), .reset(rst1), .bus(bi1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for dut0
    logic [32:0] mq[$];
    logic [31:0] mmem [256];
    logic [15:0] mcount;
    bit          last_fire;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 256; i++) mmem[i] = '0;
        mcount = '0;
    endtask

    // One cycle on dut0, entered and left at a falling edge
    task automatic step(input bit v, input bit w, input logic [7:0] a,
                        input logic [31:0] d, input bit rr, input bit ck);
        bit exp_ready;
        bi0.req_valid  = v;
        bi0.req_write  = w;
        bi0.req_addr   = a;
        bi0.req_wdata  = d;
        bi0.resp_ready = rr;
        #1;
        exp_ready = (mq.size() < DEPTH);
        if (ck) begin
            chk("req_ready", 64'(bi0.req_ready), 64'(exp_ready));
            chk("resp_valid", 64'(bi0.resp_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("resp_write", 64'(bi0.resp_write), 64'(mq[0][32]));
                chk("resp_data", 64'(bi0.resp_data), 64'(mq[0][31:0]));
            end
        end
        last_fire = v && exp_ready;
        if (mq.size() != 0 && rr) void'(mq.pop_front());
        if (last_fire) begin
            if (w) begin
                mq.push_back({1'b1, d});
                mmem[a] = d;
            end else begin
                mq.push_back({1'b0, mmem[a]});
            end
            mcount = mcount + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
        if (ck) chk("accept_count", 64'(bi0.accept_count), 64'(mcount));
    endtask

    initial begin
        int          idx;
        logic [15:0] mlfsr;
        int          q1n;
        logic [15:0] cnt1;
        bit          exp_r1;
        logic [31:0] wd;

        rst0 = 1'b1;
        rst1 = 1'b1;
        bi0.req_valid = 0; bi0.req_write = 0; bi0.req_addr = '0; bi0.req_wdata = '0; bi0.resp_ready = 0;
        bi1.req_valid = 0; bi1.req_write = 0; bi1.req_addr = '0; bi1.req_wdata = '0; bi1.resp_ready = 0;
        model_reset();

        // Reset values of both instances
        @(negedge clk);
        chk("rst_ready0", 64'(bi0.req_ready), 64'(1));
        chk("rst_rvalid0", 64'(bi0.resp_valid), 64'(0));
        chk("rst_rwrite0", 64'(bi0.resp_write), 64'(0));
        chk("rst_rdata0", 64'(bi0.resp_data), 64'(0));
        chk("rst_count0", 64'(bi0.accept_count), 64'(0));
        chk("rst_ready1", 64'(bi1.req_ready), 64'(0));
        chk("rst_rvalid1", 64'(bi1.resp_valid), 64'(0));
        chk("rst_count1", 64'(bi1.accept_count), 64'(0));
        rst0 = 1'b0;

        // Unwritten address reads zero
        step(1, 0, 8'd200, '0, 1, 1);
        chk("rd200_valid", 64'(bi0.resp_valid), 64'(1));
        chk("rd200_data", 64'(bi0.resp_data), 64'(0));
        chk("rd200_write", 64'(bi0.resp_write), 64'(0));
        step(0, 0, '0, '0, 1, 1);

        // Reset to align the counter, then write/read address 5
        rst0 = 1'b1; model_reset(); @(negedge clk); rst0 = 1'b0;
        step(1, 1, 8'd5, 32'hDEADBEEF, 1, 1);
        chk("wr5_resp", 64'({bi0.resp_valid, bi0.resp_write, bi0.resp_data}), 64'({2'b11, 32'hDEADBEEF}));
        step(1, 0, 8'd5, '0, 1, 1);
        chk("rd5_resp", 64'({bi0.resp_valid, bi0.resp_write, bi0.resp_data}), 64'({2'b10, 32'hDEADBEEF}));
        chk("count_two", 64'(bi0.accept_count), 64'(2));
        step(0, 0, '0, '0, 1, 1);

        // Back-pressure: reads 0..7 with resp_ready low, then release
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step(1, 0, 8'(idx), '0, 0, 1);
            if (last_fire) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'(DEPTH));
        chk("bp_ready_low", 64'(bi0.req_ready), 64'(0));
        for (int c = 0; c < 40; c++) begin
            if (idx == 8 && mq.size() == 0) break;
            step(idx < 8, 0, 8'(idx), '0, 1, 1);
            if (last_fire) idx++;
        end
        chk("bp_drained", 64'(idx), 64'(8));

        // Random traffic over a narrow address range
        for (int c = 0; c < 80; c++) begin
            step(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), $urandom, 1'($urandom), 1);
        end
        for (int c = 0; c < 8; c++) step(0, 0, '0, '0, 1, 1);

        // Reset mid-burst with three responses pending and a request held
        wd = $urandom;
        step(1, 1, 8'd9, wd, 0, 1);
        step(1, 1, 8'd9, wd ^ 32'h1, 0, 1);
        step(1, 1, 8'd9, wd ^ 32'h2, 0, 1);
        chk("pending3", 64'(mq.size()), 64'(3));
        bi0.req_valid = 1; bi0.req_write = 0; bi0.req_addr = 8'd9;
        #2 rst0 = 1'b1;
        #1;
        chk("midrst_rvalid", 64'(bi0.resp_valid), 64'(0));
        chk("midrst_count", 64'(bi0.accept_count), 64'(0));
        chk("midrst_ready", 64'(bi0.req_ready), 64'(1));
        model_reset();
        @(posedge clk); @(negedge clk);
        chk("held_req_count", 64'(bi0.accept_count), 64'(0));
        rst0 = 1'b0;
        step(1, 0, 8'd9, '0, 1, 1);
        chk("rd9_after_rst", 64'(bi0.resp_data), 64'(0));
        step(0, 0, '0, '0, 1, 1);

        // Stall pattern on the LFSR-gated instance
        rst1 = 1'b0;
        mlfsr = 16'hACE1; q1n = 0; cnt1 = '0;
        for (int c = 0; c < 32; c++) begin
            bi1.req_valid = 1; bi1.req_write = 0;
            bi1.req_addr = 8'($urandom); bi1.resp_ready = 1;
            #1;
            exp_r1 = (q1n < DEPTH) && (mlfsr[0] == 1'b0);
            chk("stall_ready", 64'(bi1.req_ready), 64'(exp_r1));
            if (q1n > 0) q1n--;
            if (exp_r1) begin q1n++; cnt1 = cnt1 + 16'd1; end
            @(posedge clk);
            mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
            @(negedge clk);
        end
        chk("stall_count", 64'(bi1.accept_count), 64'(cnt1));
        bi1.req_valid = 0;

        // Counter wrap
        rst0 = 1'b1; model_reset(); @(negedge clk); rst0 = 1'b0;
        for (int c = 0; c < 65535; c++) step(1, 0, 8'(c), '0, 1, 0);
        chk("wrap_ffff", 64'(bi0.accept_count), 64'(16'hFFFF));
        chk("wrap_model", 64'(bi0.accept_count), 64'(mcount));
        step(1, 0, 8'd1, '0, 1, 1);
        chk("wrap_zero", 64'(bi0.accept_count), 64'(0));
        step(1, 0, 8'd2, '0, 1, 1);
        chk("wrap_one", 64'(bi0.accept_count), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
